// File: rtl/axis_header_inserter.sv
// AXI-Stream header inserter: prepends a 0..N byte header to every packet and
// re-packs the payload so the output stream stays byte-contiguous.
module axis_header_inserter #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD / 8,
    parameter int CNT_WD       = $clog2(DATA_BYTE_WD + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    input  logic                    valid_insert,
    input  logic [DATA_WD-1:0]      header_insert,
    input  logic [DATA_BYTE_WD-1:0] keep_insert,
    output logic                    ready_insert,
    output logic                    keep_err
);
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FLUSH} state_t;

    localparam logic [DATA_BYTE_WD-1:0] KEEP_ONE  = DATA_BYTE_WD'(1);
    localparam logic [DATA_BYTE_WD-1:0] KEEP_FULL = '1;
    localparam logic [CNT_WD-1:0]       CNT_N     = CNT_WD'(DATA_BYTE_WD);
    localparam logic [CNT_WD:0]         SUM_N     = (CNT_WD + 1)'(DATA_BYTE_WD);

    function automatic logic [CNT_WD-1:0] popcount(input logic [DATA_BYTE_WD-1:0] v);
        logic [CNT_WD-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) c = c + CNT_WD'(v[i]);
        return c;
    endfunction

    function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [CNT_WD-1:0] k);
        return ~(KEEP_FULL >> k);
    endfunction

    function automatic logic [DATA_WD-1:0] byte_mask(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++) m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    state_t                  state_q, state_d;
    logic [DATA_WD-1:0]      residue_q, residue_d;
    logic [CNT_WD-1:0]       cnt_q, cnt_d;
    logic                    valid_q, valid_d;
    logic [DATA_WD-1:0]      data_q, data_d;
    logic [DATA_BYTE_WD-1:0] keep_q, keep_d;
    logic                    last_q, last_d;
    logic                    err_q, err_d;

    logic                    out_free, hdr_fire, in_fire;
    logic                    hdr_legal, in_legal;
    logic [CNT_WD-1:0]       hdr_cnt, in_k, in_cnt;
    logic [CNT_WD:0]         total;
    logic [DATA_BYTE_WD-1:0] in_keep_eff;
    logic [2*DATA_WD-1:0]    packed_w;

    assign out_free     = !valid_q || ready_out;
    assign ready_insert = !rst && (state_q == S_IDLE);
    assign ready_in     = !rst && (state_q == S_STREAM) && out_free;
    assign hdr_fire     = valid_insert && ready_insert;
    assign in_fire      = valid_in && ready_in;

    // The upper half of packed_w is the next output beat, the lower half the new residue.
    always_comb begin
        hdr_legal   = (keep_insert & (keep_insert + KEEP_ONE)) == '0;
        hdr_cnt     = hdr_legal ? popcount(keep_insert) : '0;
        in_k        = popcount(keep_in);
        in_legal    = (keep_in == top_mask(in_k)) && (last_in || (in_k == CNT_N));
        in_keep_eff = in_legal ? keep_in : KEEP_FULL;
        in_cnt      = in_legal ? in_k : CNT_N;
        total       = {1'b0, cnt_q} + {1'b0, in_cnt};
        packed_w    = {residue_q, {DATA_WD{1'b0}}}
                    | ({data_in & byte_mask(in_keep_eff), {DATA_WD{1'b0}}} >> (int'(cnt_q) * 8));
    end

    always_comb begin
        state_d   = state_q;
        residue_d = residue_q;
        cnt_d     = cnt_q;
        valid_d   = out_free ? 1'b0 : valid_q;
        data_d    = data_q;
        keep_d    = keep_q;
        last_d    = last_q;
        err_d     = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (hdr_fire) begin
                    residue_d = header_insert << ((DATA_BYTE_WD - int'(hdr_cnt)) * 8);
                    cnt_d     = hdr_cnt;
                    err_d     = !hdr_legal;
                    state_d   = S_STREAM;
                end
            end
            S_STREAM: begin
                if (in_fire) begin
                    err_d   = !in_legal;
                    valid_d = 1'b1;
                    data_d  = packed_w[2*DATA_WD-1 -: DATA_WD];
                    if (!last_in) begin
                        keep_d    = KEEP_FULL;
                        last_d    = 1'b0;
                        residue_d = packed_w[DATA_WD-1:0];
                    end else if (total <= SUM_N) begin
                        keep_d    = top_mask(total[CNT_WD-1:0]);
                        last_d    = 1'b1;
                        residue_d = '0;
                        cnt_d     = '0;
                        state_d   = S_IDLE;
                    end else begin
                        // Tail spills over one beat: emit a full beat now, the rest in FLUSH.
                        keep_d    = KEEP_FULL;
                        last_d    = 1'b0;
                        residue_d = packed_w[DATA_WD-1:0];
                        cnt_d     = CNT_WD'(total - SUM_N);
                        state_d   = S_FLUSH;
                    end
                end
            end
            S_FLUSH: begin
                if (out_free) begin
                    valid_d   = 1'b1;
                    data_d    = residue_q;
                    keep_d    = top_mask(cnt_q);
                    last_d    = 1'b1;
                    residue_d = '0;
                    cnt_d     = '0;
                    state_d   = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_IDLE;
            residue_q <= '0;
            cnt_q     <= '0;
            valid_q   <= 1'b0;
            data_q    <= '0;
            keep_q    <= '0;
            last_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            residue_q <= residue_d;
            cnt_q     <= cnt_d;
            valid_q   <= valid_d;
            data_q    <= data_d;
            keep_q    <= keep_d;
            last_q    <= last_d;
            err_q     <= err_d;
        end
    end

    assign valid_out = valid_q;
    assign data_out  = data_q;
    assign keep_out  = keep_q;
    assign last_out  = last_q;
    assign keep_err  = err_q;
endmodule

// File: tb/tb_axis_header_inserter.sv
// Self-checking bench for axis_header_inserter with a 4-byte bus: directed packet table,
// reset/flush corner sequences and random back-to-back packets checked through a scoreboard.
module tb_axis_header_inserter;
    localparam int DW = 32;
    localparam int NB = DW / 8;
    localparam logic [NB-1:0] KFULL = '1;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [NB-1:0] keep;
        logic          last;
    } beat_t;

    typedef struct {
        logic [DW-1:0]      hdr;
        logic [NB-1:0]      hkeep;
        int                 n_in;
        logic [0:2][DW-1:0] in_data;
        logic [0:2][NB-1:0] in_keep;
        int                 n_out;
        logic [0:3][DW-1:0] out_data;
        logic [0:3][NB-1:0] out_keep;
        logic [0:3]         out_last;
        int                 n_err;
        int                 rmode;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          valid_in = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [NB-1:0] keep_in = '0;
    logic          last_in = 1'b0;
    logic          ready_in;
    logic          valid_out;
    logic [DW-1:0] data_out;
    logic [NB-1:0] keep_out;
    logic          last_out;
    logic          ready_out = 1'b1;
    logic          valid_insert = 1'b0;
    logic [DW-1:0] header_insert = '0;
    logic [NB-1:0] keep_insert = '0;
    logic          ready_insert;
    logic          keep_err;

    int    n_checks = 0;
    int    n_pass = 0;
    int    err_seen = 0;
    int    rdy_mode = 0;
    bit    payload_phase = 1'b0;
    bit    stalled = 1'b0;
    beat_t stall_beat;
    beat_t sb_q[$];
    vec_t  vecs[8];
    logic [DW-1:0] rnd_data[4];
    logic [NB-1:0] rnd_keep[4];

    axis_header_inserter #(.DATA_WD(DW)) dut (
        .clk(clk), .rst(rst),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in),
        .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out),
        .ready_out(ready_out),
        .valid_insert(valid_insert), .header_insert(header_insert), .keep_insert(keep_insert),
        .ready_insert(ready_insert), .keep_err(keep_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        case (rdy_mode)
            0: ready_out = 1'b1;
            1: ready_out = ~ready_out;
            2: ready_out = 1'($urandom_range(0, 1));
            default: ready_out = 1'b0;
        endcase
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation still running, required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [DW-1:0] bmask(input logic [NB-1:0] k);
        logic [DW-1:0] m;
        m = '0;
        for (int i = 0; i < NB; i++) if (k[i]) m[i*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, req, $time);
    endtask

    task automatic checkOutput();
        beat_t e;
        if (sb_q.size() == 0) begin
            n_checks++;
            $display("[TB] FAIL unexpected_beat: got data 0x%h keep %b last %b, required no beat",
                     data_out, keep_out, last_out);
        end else begin
            e = sb_q.pop_front();
            check_val("out_beat {data,keep,last}",
                      {27'd0, data_out & bmask(e.keep), keep_out, last_out},
                      {27'd0, e.data & bmask(e.keep), e.keep, e.last});
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled)
                check_val("stall_hold", {valid_out, data_out, keep_out, last_out}, {1'b1, stall_beat});
            if (payload_phase)
                check_val("ready_in_follows_out_free", 64'(ready_in), 64'(!valid_out || ready_out));
            if (keep_err) err_seen++;
            if (valid_out && ready_out) checkOutput();
            stalled    = valid_out && !ready_out;
            stall_beat = '{data: data_out, keep: keep_out, last: last_out};
        end
    end

    task automatic send_header(input logic [DW-1:0] h, input logic [NB-1:0] k);
        int budget = 0;
        valid_insert  = 1'b1;
        header_insert = h;
        keep_insert   = k;
        @(negedge clk);
        while (!ready_insert && budget < 500) begin
            budget++;
            @(negedge clk);
        end
        if (!ready_insert) begin
            n_checks++;
            $display("[TB] FAIL header_timeout: ready_insert got 0, required 1");
        end
        @(posedge clk);
        #1;
        valid_insert = 1'b0;
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [NB-1:0] k, input logic l);
        int budget = 0;
        valid_in = 1'b1;
        data_in  = d;
        keep_in  = k;
        last_in  = l;
        @(negedge clk);
        while (!ready_in && budget < 500) begin
            budget++;
            @(negedge clk);
        end
        if (!ready_in) begin
            n_checks++;
            $display("[TB] FAIL payload_timeout: ready_in got 0, required 1");
        end
        @(posedge clk);
        #1;
        valid_in = 1'b0;
        last_in  = 1'b0;
    endtask

    task automatic drain();
        int budget = 0;
        while ((sb_q.size() != 0 || valid_out) && budget < 500) begin
            budget++;
            @(negedge clk);
        end
        if (budget >= 500) begin
            n_checks++;
            $display("[TB] FAIL drain_timeout: got %0d beats pending, required 0", sb_q.size());
        end
        @(negedge clk);
    endtask

    task automatic applyStimulus(input vec_t v);
        beat_t b;
        rdy_mode = v.rmode;
        err_seen = 0;
        for (int i = 0; i < v.n_out; i++) begin
            b.data = v.out_data[i];
            b.keep = v.out_keep[i];
            b.last = v.out_last[i];
            sb_q.push_back(b);
        end
        send_header(v.hdr, v.hkeep);
        payload_phase = 1'b1;
        for (int i = 0; i < v.n_in; i++)
            send_beat(v.in_data[i], v.in_keep[i], 1'(i == v.n_in - 1));
        payload_phase = 1'b0;
        if (v.n_out > v.n_in) begin
            @(negedge clk);
            check_val("flush_ready_in", 64'(ready_in), 64'd0);
        end
        drain();
        check_val("keep_err_cycles", 64'(err_seen), 64'(v.n_err));
    endtask

    // Reference: flatten header and payload into a byte list, then cut it into N-byte beats.
    task automatic model_push(input logic [DW-1:0] h, input int hc, input int nb);
        logic [7:0] bq[$];
        beat_t      b;
        int         k;
        int         c;
        for (int j = hc - 1; j >= 0; j--) bq.push_back(h[j*8 +: 8]);
        for (int i = 0; i < nb; i++) begin
            k = $countones(rnd_keep[i]);
            for (int j = 0; j < k; j++) bq.push_back(rnd_data[i][(NB-1-j)*8 +: 8]);
        end
        while (bq.size() > 0) begin
            b.data = '0;
            c = 0;
            for (int j = 0; j < NB; j++) begin
                if (bq.size() > 0) begin
                    b.data[(NB-1-j)*8 +: 8] = bq.pop_front();
                    c++;
                end
            end
            b.keep = ~(KFULL >> c);
            b.last = (bq.size() == 0);
            sb_q.push_back(b);
        end
    endtask

    initial begin
        vecs[0] = '{hdr: 32'h0000AABB, hkeep: 4'b0011, n_in: 2,
                    in_data: {32'h11223344, 32'h55667788, 32'h0}, in_keep: {4'b1111, 4'b1100, 4'b0},
                    n_out: 2, out_data: {32'hAABB1122, 32'h33445566, 32'h0, 32'h0},
                    out_keep: {4'b1111, 4'b1111, 4'b0, 4'b0}, out_last: 4'b0100, n_err: 0, rmode: 0};
        vecs[1] = '{hdr: 32'h0000AABB, hkeep: 4'b0011, n_in: 2,
                    in_data: {32'h11223344, 32'h55667788, 32'h0}, in_keep: {4'b1111, 4'b1110, 4'b0},
                    n_out: 3, out_data: {32'hAABB1122, 32'h33445566, 32'h77000000, 32'h0},
                    out_keep: {4'b1111, 4'b1111, 4'b1000, 4'b0}, out_last: 4'b0010, n_err: 0, rmode: 0};
        vecs[2] = '{hdr: 32'hFFFFFFFF, hkeep: 4'b0000, n_in: 3,
                    in_data: {32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1000000}, in_keep: {4'b1111, 4'b1111, 4'b1000},
                    n_out: 3, out_data: {32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1000000, 32'h0},
                    out_keep: {4'b1111, 4'b1111, 4'b1000, 4'b0}, out_last: 4'b0010, n_err: 0, rmode: 0};
        vecs[3] = '{hdr: 32'hDEADBEEF, hkeep: 4'b1111, n_in: 1,
                    in_data: {32'h01020304, 32'h0, 32'h0}, in_keep: {4'b1111, 4'b0, 4'b0},
                    n_out: 2, out_data: {32'hDEADBEEF, 32'h01020304, 32'h0, 32'h0},
                    out_keep: {4'b1111, 4'b1111, 4'b0, 4'b0}, out_last: 4'b0100, n_err: 0, rmode: 0};
        vecs[4] = vecs[0];
        vecs[4].rmode = 1;
        vecs[5] = '{hdr: 32'h12345678, hkeep: 4'b0101, n_in: 1,
                    in_data: {32'hCAFEBABE, 32'h0, 32'h0}, in_keep: {4'b1111, 4'b0, 4'b0},
                    n_out: 1, out_data: {32'hCAFEBABE, 32'h0, 32'h0, 32'h0},
                    out_keep: {4'b1111, 4'b0, 4'b0, 4'b0}, out_last: 4'b1000, n_err: 1, rmode: 0};
        vecs[6] = '{hdr: 32'h000000EE, hkeep: 4'b0001, n_in: 2,
                    in_data: {32'h11223344, 32'h55667788, 32'h0}, in_keep: {4'b1100, 4'b1100, 4'b0},
                    n_out: 2, out_data: {32'hEE112233, 32'h44556600, 32'h0, 32'h0},
                    out_keep: {4'b1111, 4'b1110, 4'b0, 4'b0}, out_last: 4'b0100, n_err: 1, rmode: 0};
        vecs[7] = '{hdr: 32'h0, hkeep: 4'b0000, n_in: 1,
                    in_data: {32'h0A0B0C0D, 32'h0, 32'h0}, in_keep: {4'b0101, 4'b0, 4'b0},
                    n_out: 1, out_data: {32'h0A0B0C0D, 32'h0, 32'h0, 32'h0},
                    out_keep: {4'b1111, 4'b0, 4'b0, 4'b0}, out_last: 4'b1000, n_err: 1, rmode: 0};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_val("reset_valid_out", 64'(valid_out), 64'd0);
        check_val("reset_data_out", 64'(data_out), 64'd0);
        check_val("reset_keep_out", 64'(keep_out), 64'd0);
        check_val("reset_last_out", 64'(last_out), 64'd0);
        check_val("reset_keep_err", 64'(keep_err), 64'd0);
        check_val("reset_ready_in", 64'(ready_in), 64'd0);
        check_val("reset_ready_insert", 64'(ready_insert), 64'd0);
        #2 rst = 1'b0;
        @(negedge clk);
        check_val("idle_ready_insert", 64'(ready_insert), 64'd1);
        check_val("idle_ready_in", 64'(ready_in), 64'd0);

        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(vecs[i]);
        end

        // Mid-packet reset while an output beat is stalled downstream.
        @(posedge clk);
        #1;
        rdy_mode = 3;
        send_header(32'h0000AABB, 4'b0011);
        send_beat(32'h11223344, 4'b1111, 1'b0);
        @(negedge clk);
        check_val("pre_rst_stalled_valid", 64'(valid_out), 64'd1);
        #2 rst = 1'b1;
        #1;
        check_val("rst_valid_out", 64'(valid_out), 64'd0);
        check_val("rst_data_out", 64'(data_out), 64'd0);
        check_val("rst_keep_out", 64'(keep_out), 64'd0);
        check_val("rst_last_out", 64'(last_out), 64'd0);
        check_val("rst_ready_in", 64'(ready_in), 64'd0);
        check_val("rst_ready_insert", 64'(ready_insert), 64'd0);
        @(negedge clk);
        #2 rst = 1'b0;
        sb_q.delete();
        rdy_mode = 0;
        repeat (3) @(negedge clk);
        check_val("post_rst_no_beat", 64'(valid_out), 64'd0);
        check_val("post_rst_idle", 64'(ready_insert), 64'd1);
        @(posedge clk);
        #1;
        applyStimulus(vecs[0]);

        // Random back-to-back packets under random backpressure.
        @(posedge clk);
        #1;
        rdy_mode = 2;
        err_seen = 0;
        for (int p = 0; p < 25; p++) begin
            int            hc;
            int            nb;
            int            k;
            logic [DW-1:0] h;
            logic [NB-1:0] hk;
            hc = $urandom_range(0, NB);
            nb = $urandom_range(1, 4);
            h  = $urandom;
            hk = NB'((1 << hc) - 1);
            for (int i = 0; i < nb; i++) begin
                rnd_data[i] = $urandom;
                if (i < nb - 1) begin
                    rnd_keep[i] = KFULL;
                end else begin
                    k = $urandom_range(1, NB);
                    rnd_keep[i] = ~(KFULL >> k);
                end
            end
            model_push(h, hc, nb);
            send_header(h, hk);
            payload_phase = 1'b1;
            for (int i = 0; i < nb; i++) send_beat(rnd_data[i], rnd_keep[i], 1'(i == nb - 1));
            payload_phase = 1'b0;
        end
        drain();
        check_val("random_keep_err", 64'(err_seen), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
